// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the memory-port arbiter: arbiter state encoding,
// default parameter values and the requester identifiers.
// ---------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

  localparam int unsigned STREAK_MAX_DEFAULT = 32'd4;
  localparam int unsigned TIMEOUT_DEFAULT    = 32'd64;
  localparam int unsigned AW_DEFAULT         = 32'd32;
  localparam int unsigned DW_DEFAULT         = 32'd32;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/arb_watchdog.sv
// ---------------------------------------------------------------------------
// arb_watchdog
// Loadable down-counter guarding one backend transfer. While clear_i is high
// the counter is loaded with TIMEOUT-1; while en_i is high it counts down and
// expire_o flags the cycle in which it sits at zero (TIMEOUT-1 cycles after
// the first enabled cycle).
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clear_i      : reload the counter (arbiter idle)
//   en_i         : count (transfer in flight)
//   expire_o     : counter exhausted in an enabled cycle
// ---------------------------------------------------------------------------
module arb_watchdog
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned   CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ZERO = {CW{1'b0}};

  logic [CW-1:0] count_q;

  // Reload on clear, count down while enabled, hold at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= ZERO;
    end else if (clear_i) begin
      count_q <= LOAD;
    end else if (en_i && (count_q != ZERO)) begin
      count_q <= count_q - CW'(1'b1);
    end
  end

  assign expire_o = en_i & ~clear_i & (count_q == ZERO);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one variable-latency memory port between instruction fetch (IF) and
// the data stage (D). Data wins ties unless it has already been granted
// STREAK_MAX times in a row while IF was waiting. Each transfer raises
// mem_req_o until mem_ack_i (or a watchdog abort), then pulses the winner's
// done output for one cycle together with the registered read data.
//   if_req_i/if_addr_i                   : fetch request (held until if_done_o)
//   if_done_o/if_data_o                  : fetch completion pulse / data
//   d_req_i/d_we_i/d_addr_i/d_wdata_i    : data request (held until d_done_o)
//   d_done_o/d_rdata_o                   : data completion pulse / load data
//   mem_req_o/mem_we_o/mem_addr_o/
//   mem_wdata_o/mem_ack_i/mem_rdata_i    : backend handshake
//   stall_o                              : some request still outstanding
//   err_o                                : pulse with done on watchdog abort
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned STREAK_MAX = STREAK_MAX_DEFAULT,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT,
  parameter int unsigned AW         = AW_DEFAULT,
  parameter int unsigned DW         = DW_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_done_o,
  output logic [DW-1:0] if_data_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_done_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          stall_o,
  output logic          err_o
);

  localparam int unsigned   SW         = $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_TOP = SW'(STREAK_MAX);
  localparam logic [SW-1:0] STREAK_0   = {SW{1'b0}};

  arb_state_e    state_q;
  logic [SW-1:0] streak_q;
  logic          if_done_q, d_done_q, err_q, mem_req_q, mem_we_q;
  logic [DW-1:0] if_data_q, d_rdata_q, mem_wdata_q;
  logic [AW-1:0] mem_addr_q;

  logic if_elig, d_elig, at_top, grant, grant_id, wd_clear, wd_en, wd_expire;

  // Eligibility masks the stale request still present in the done cycle.
  always_comb begin
    if_elig  = if_req_i & ~if_done_q;
    d_elig   = d_req_i & ~d_done_q;
    at_top   = (streak_q == STREAK_TOP);
    grant    = 1'b0;
    grant_id = REQ_IF;
    if (state_q == ARB_IDLE) begin
      if (d_elig && !(if_elig && at_top)) begin
        grant    = 1'b1;
        grant_id = REQ_D;
      end else if (if_elig) begin
        grant    = 1'b1;
        grant_id = REQ_IF;
      end else begin
        grant    = 1'b0;
        grant_id = REQ_IF;
      end
    end else begin
      grant    = 1'b0;
      grant_id = REQ_IF;
    end
  end

  assign wd_clear = (state_q == ARB_IDLE);
  assign wd_en    = ~wd_clear;

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (wd_clear),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      streak_q    <= STREAK_0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
      if_data_q   <= {DW{1'b0}};
      d_rdata_q   <= {DW{1'b0}};
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (grant) begin
            mem_req_q <= 1'b1;
            if (grant_id == REQ_D) begin
              state_q     <= ARB_BUSY_D;
              mem_we_q    <= d_we_i;
              mem_addr_q  <= d_addr_i;
              mem_wdata_q <= d_wdata_i;
              // Only grants that pass over a waiting fetch extend the streak.
              if (!if_elig) begin
                streak_q <= STREAK_0;
              end else if (!at_top) begin
                streak_q <= streak_q + SW'(1'b1);
              end
            end else begin
              state_q     <= ARB_BUSY_I;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= if_addr_i;
              mem_wdata_q <= {DW{1'b0}};
              streak_q    <= STREAK_0;
            end
          end
        end
        ARB_BUSY_I, ARB_BUSY_D: begin
          // An ack in the expiry cycle still completes normally.
          if (mem_ack_i || wd_expire) begin
            mem_req_q <= 1'b0;
            state_q   <= ARB_IDLE;
            err_q     <= ~mem_ack_i;
            if (state_q == ARB_BUSY_I) begin
              if_done_q <= 1'b1;
              if_data_q <= mem_ack_i ? mem_rdata_i : {DW{1'b0}};
            end else begin
              d_done_q <= 1'b1;
              if (!mem_ack_i) begin
                d_rdata_q <= {DW{1'b0}};
              end else if (!mem_we_q) begin
                d_rdata_q <= mem_rdata_i;
              end
            end
          end
        end
        default: begin
          state_q   <= ARB_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_done_o   = if_done_q;
  assign if_data_o   = if_data_q;
  assign d_done_o    = d_done_q;
  assign d_rdata_o   = d_rdata_q;
  assign err_o       = err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign stall_o     = if_elig | d_elig;

endmodule
